// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in the execute stage.
// Returns {remainder, quotient} with a one-cycle ready pulse; annul cancels an operation in flight.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             neg1;
    logic             neg2;
    logic             sgn;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;

    // One restoring step: the borrow out of the WIDTH+1 bit subtract decides the quotient bit.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
        q_fix = (sgn && (neg1 != neg2)) ? -quo_n : quo_n;
        r_fix = (sgn && neg1) ? -rem_n : rem_n;
        abs1  = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        abs2  = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FREE: begin
                if (start) begin
                    state_next = (opdata2 == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: state_next = S_END;
            S_ON: begin
                if (cnt == CW'(ITER - 1)) begin
                    state_next = S_END;
                end
            end
            S_END:   state_next = S_FREE;
            default: state_next = S_FREE;
        endcase
        if (annul) begin
            state_next = S_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FREE;
            ready   <= 1'b0;
            busy    <= 1'b0;
            result  <= '0;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            neg1    <= 1'b0;
            neg2    <= 1'b0;
            sgn     <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == S_END);
            busy  <= (state_next != S_FREE);

            if (state == S_FREE && state_next == S_ON) begin
                quo     <= abs1;
                divisor <= abs2;
                rem     <= '0;
                neg1    <= opdata1[WIDTH-1];
                neg2    <= opdata2[WIDTH-1];
                sgn     <= signed_div;
                cnt     <= '0;
            end else if (state == S_ON) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt + CW'(1);
            end

            if (annul) begin
                cnt <= '0;
            end

            // state_next is S_END only when annul is low, so an annulled op leaves result untouched.
            if (state_next == S_END) begin
                result <= (state == S_BYZERO) ? '0 : {r_fix, q_fix};
            end
        end
    end

endmodule
